router_ctrl: RTL and testbench

- Ingress controller for the 1x3 packet router.
- Accepts the serial byte stream from the source, decodes the destination from the header, and sequences writes into one of three output FIFOs, including the FIFO's first-byte marker (lfd_state).
- Handles FIFO back-pressure via busy, checks packet parity, and generates per-port soft resets when a destination stops reading.

---
 rtl/router_ctrl_if.sv | 26 ++
 rtl/router_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_router_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/router_ctrl_if.sv
// Router ingress bundle: source byte stream, FIFO status/strobes and destination reads.
// master = source/FIFO/destination side, slave = router_ctrl.
interface router_ctrl_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       busy;
  logic [7:0] fifo_din;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
  logic       err;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    input  busy, fifo_din, write_enb, lfd_state, vld_out, soft_reset, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    output busy, fifo_din, write_enb, lfd_state, vld_out, soft_reset, err
  );
endinterface

// File: rtl/router_ctrl.sv
// Ingress controller of the 1x3 router: header decode, FIFO write sequencing, back-pressure,
// per-port read timeout. Parity checking and err are built only with ROUTER_PARITY_CHK_EN.
module router_ctrl #(
  parameter int unsigned TIMEOUT = 30
) (
  input logic          clock,
  input logic          resetn,
  router_ctrl_if.slave rif
);

  typedef enum logic [2:0] {
    StIdle, StWaitEmpty, StLoadFirst, StLoadData, StCheckParity, StDrop
  } state_e;

  localparam logic [4:0] TimeoutMax = 5'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic [5:0]  len_q, len_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [5:0]  rem_q, rem_d;
  logic [7:0]  din_q, din_d;
  logic        dvld_q, dvld_d;
`ifdef ROUTER_PARITY_CHK_EN
  logic [7:0]  parity_q, parity_d;
  logic [7:0]  par_byte_q, par_byte_d;
  logic        err_q, err_d;
`endif
  logic [4:0]  tcnt_q [3];
  logic [4:0]  tcnt_d [3];
  logic [2:0]  vld_out, soft_reset, write_enb;
  logic        busy, lfd_state, accept, wr, sr;

  assign vld_out = ~rif.fifo_empty;

  // Timeout: a port holding data that nobody reads gets a one-cycle soft reset.
  always_comb begin
    soft_reset = '0;
    tcnt_d     = tcnt_q;
    for (int k = 0; k < 3; k++) begin
      if (!(vld_out[k] && !rif.read_enb[k])) begin
        tcnt_d[k] = '0;
      end else if (tcnt_q[k] == TimeoutMax) begin
        tcnt_d[k]     = '0;
        soft_reset[k] = 1'b1;
      end else begin
        tcnt_d[k] = tcnt_q[k] + 5'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    hdr_d     = hdr_q;
    rem_d     = rem_q;
    din_d     = din_q;
    dvld_d    = dvld_q;
`ifdef ROUTER_PARITY_CHK_EN
    parity_d   = parity_q;
    par_byte_d = par_byte_q;
    err_d      = err_q;
`endif
    busy      = 1'b0;
    lfd_state = 1'b0;
    write_enb = '0;
    accept    = 1'b0;
    wr        = dvld_q && !rif.fifo_full[addr_q];
    sr        = soft_reset[addr_q];
    unique case (state_q)
      StIdle: begin
        if (rif.pkt_valid) begin
          rem_d = rif.data_in[7:2];
          if (rif.data_in[1:0] == 2'd3) begin
            state_d = StDrop;
          end else begin
            addr_d  = rif.data_in[1:0];
            len_d   = rif.data_in[7:2];
            hdr_d   = rif.data_in;
`ifdef ROUTER_PARITY_CHK_EN
            parity_d = rif.data_in;
            err_d    = 1'b0;
`endif
            state_d = rif.fifo_empty[rif.data_in[1:0]] ? StLoadFirst : StWaitEmpty;
          end
        end
      end
      StWaitEmpty: begin
        busy = 1'b1;
        if (sr) state_d = StDrop;
        else if (rif.fifo_empty[addr_q]) state_d = StLoadFirst;
      end
      StLoadFirst: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        if (sr) begin
          state_d = StDrop;
        end else begin
          din_d   = hdr_q;
          dvld_d  = 1'b1;
          rem_d   = len_q;
          state_d = StLoadData;
        end
      end
      StLoadData: begin
        write_enb[addr_q] = wr;
        busy   = dvld_q && rif.fifo_full[addr_q];
        accept = rif.pkt_valid && !busy;
        if (wr) dvld_d = 1'b0;
        if (accept) begin
          din_d  = rif.data_in;
          dvld_d = 1'b1;
          if (rem_q != 6'd0) begin
            rem_d = rem_q - 6'd1;
`ifdef ROUTER_PARITY_CHK_EN
            parity_d = parity_q ^ rif.data_in;
`endif
          end else begin
`ifdef ROUTER_PARITY_CHK_EN
            par_byte_d = rif.data_in;
`endif
            state_d = StCheckParity;
          end
        end
        // A byte accepted on the reset edge is consumed; a consumed parity byte ends the packet.
        if (sr) begin
          dvld_d  = 1'b0;
          state_d = (accept && rem_q == 6'd0) ? StIdle : StDrop;
        end
      end
      StCheckParity: begin
        busy              = 1'b1;
        write_enb[addr_q] = wr;
        if (wr) dvld_d = 1'b0;
        if (!dvld_q) begin
`ifdef ROUTER_PARITY_CHK_EN
          err_d = (parity_q != par_byte_q);
`endif
          state_d = StIdle;
        end
        if (sr) begin
          dvld_d  = 1'b0;
`ifdef ROUTER_PARITY_CHK_EN
          err_d   = err_q;
`endif
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (rif.pkt_valid) begin
          if (rem_q == 6'd0) state_d = StIdle;
          else rem_d = rem_q - 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      hdr_q   <= '0;
      rem_q   <= '0;
      din_q   <= '0;
      dvld_q  <= 1'b0;
      for (int k = 0; k < 3; k++) tcnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      hdr_q   <= hdr_d;
      rem_q   <= rem_d;
      din_q   <= din_d;
      dvld_q  <= dvld_d;
      for (int k = 0; k < 3; k++) tcnt_q[k] <= tcnt_d[k];
    end
  end

`ifdef ROUTER_PARITY_CHK_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      parity_q   <= '0;
      par_byte_q <= '0;
      err_q      <= 1'b0;
    end else begin
      parity_q   <= parity_d;
      par_byte_q <= par_byte_d;
      err_q      <= err_d;
    end
  end
  assign rif.err = err_q;
`else
  assign rif.err = 1'b0;
`endif

  assign rif.busy       = busy;
  assign rif.fifo_din   = din_q;
  assign rif.write_enb  = write_enb;
  assign rif.lfd_state  = lfd_state;
  assign rif.vld_out    = vld_out;
  assign rif.soft_reset = soft_reset;

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: routing, parity, back-pressure, drop, wait-empty, timeouts.
module tb_router_ctrl;

`ifdef ROUTER_PARITY_CHK_EN
  localparam logic ParEn = 1'b1;
`else
  localparam logic ParEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   nvec = 0;
  int   nfail = 0;
  int   sr_cyc;

  router_ctrl_if rif ();

  router_ctrl #(.TIMEOUT(30)) dut (
    .clock  (clock),
    .resetn (resetn),
    .rif    (rif)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // p[0] is the header; destination FIFO empty and never full.
  task automatic send_pkt(input logic [7:0] p[$], input logic [2:0] we_exp);
    rif.pkt_valid = 1'b1;
    rif.data_in   = p[0];
    #1;
    chk("idle_busy", 8'(rif.busy), 8'd0);
    tick;
    rif.data_in = p[1];
    #1;
    chk("lfd_on", 8'(rif.lfd_state), 8'd1);
    chk("lfd_busy", 8'(rif.busy), 8'd1);
    chk("lfd_we", 8'(rif.write_enb), 8'd0);
    chk("lfd_err", 8'(rif.err), 8'd0);
    tick;
    for (int i = 1; i < p.size(); i++) begin
      rif.data_in = p[i];
      #1;
      chk("ld_we", 8'(rif.write_enb), 8'(we_exp));
      chk("ld_din", rif.fifo_din, p[i-1]);
      chk("ld_lfd", 8'(rif.lfd_state), 8'd0);
      tick;
    end
    rif.pkt_valid = 1'b0;
    #1;
    chk("cp_we", 8'(rif.write_enb), 8'(we_exp));
    chk("cp_din", rif.fifo_din, p[p.size()-1]);
    chk("cp_busy", 8'(rif.busy), 8'd1);
    tick;
    chk("drain_we", 8'(rif.write_enb), 8'd0);
    tick;
    chk("done_busy", 8'(rif.busy), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.pkt_valid  = 1'b0;
    rif.data_in    = 8'h00;
    rif.fifo_full  = 3'b000;
    rif.fifo_empty = 3'b111;
    rif.read_enb   = 3'b000;
    #12;
    chk("rst_busy", 8'(rif.busy), 8'd0);
    chk("rst_din", rif.fifo_din, 8'h00);
    chk("rst_we", 8'(rif.write_enb), 8'd0);
    chk("rst_lfd", 8'(rif.lfd_state), 8'd0);
    chk("rst_sr", 8'(rif.soft_reset), 8'd0);
    chk("rst_err", 8'(rif.err), 8'd0);
    chk("rst_vld", 8'(rif.vld_out), 8'd0);
    resetn = 1'b1;
    tick;

    // len 3 addr 1; good parity = 0D^11^22^33 = 0D
    send_pkt('{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D}, 3'b010);
    chk("good_err", 8'(rif.err), 8'd0);

    send_pkt('{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00}, 3'b010);
    chk("bad_err", 8'(rif.err), 8'(ParEn));
    tick;
    chk("bad_err_hold", 8'(rif.err), 8'(ParEn));

    // Back-pressure on FIFO1 while 0x22 is held.
    rif.pkt_valid = 1'b1;
    rif.data_in   = 8'h0D;
    tick;
    rif.data_in = 8'h11;
    tick;
    tick;
    rif.data_in = 8'h22;
    tick;
    rif.data_in   = 8'h33;
    rif.fifo_full = 3'b010;
    #1;
    chk("bp_busy", 8'(rif.busy), 8'd1);
    chk("bp_we", 8'(rif.write_enb), 8'd0);
    chk("bp_din", rif.fifo_din, 8'h22);
    tick;
    chk("bp_hold", rif.fifo_din, 8'h22);
    chk("bp_busy2", 8'(rif.busy), 8'd1);
    tick;
    rif.fifo_full = 3'b000;
    #1;
    chk("bp_rel_we", 8'(rif.write_enb), 8'b010);
    chk("bp_rel_din", rif.fifo_din, 8'h22);
    chk("bp_rel_busy", 8'(rif.busy), 8'd0);
    tick;
    rif.data_in = 8'h0D;
    #1;
    chk("bp_next_din", rif.fifo_din, 8'h33);
    chk("bp_next_we", 8'(rif.write_enb), 8'b010);
    tick;
    rif.pkt_valid = 1'b0;
    chk("bp_par_din", rif.fifo_din, 8'h0D);
    tick;
    tick;
    chk("bp_idle", 8'(rif.busy), 8'd0);
    chk("bp_err_clr", 8'(rif.err), 8'd0);

    // addr 3 len 1: header + 2 bytes dropped.
    rif.pkt_valid = 1'b1;
    rif.data_in   = 8'h07;
    tick;
    for (int i = 0; i < 2; i++) begin
      rif.data_in = 8'hA5;
      #1;
      chk("drop_busy", 8'(rif.busy), 8'd0);
      chk("drop_we", 8'(rif.write_enb), 8'd0);
      tick;
    end
    send_pkt('{8'h02, 8'h02}, 3'b100);

    // Header to FIFO0 while it is not empty.
    rif.fifo_empty = 3'b110;
    rif.pkt_valid  = 1'b1;
    rif.data_in    = 8'h04;
    tick;
    rif.data_in = 8'h99;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("we_busy", 8'(rif.busy), 8'd1);
      chk("we_lfd", 8'(rif.lfd_state), 8'd0);
      chk("we_vld", 8'(rif.vld_out), 8'b001);
      tick;
    end
    rif.fifo_empty = 3'b111;
    #1;
    chk("we_last_lfd", 8'(rif.lfd_state), 8'd0);
    tick;
    chk("we_lfd_on", 8'(rif.lfd_state), 8'd1);
    tick;
    chk("we_hdr_din", rif.fifo_din, 8'h04);
    chk("we_hdr_we", 8'(rif.write_enb), 8'b001);
    tick;
    rif.data_in = 8'h9D;
    chk("we_pay_din", rif.fifo_din, 8'h99);
    tick;
    rif.pkt_valid = 1'b0;
    chk("we_par_din", rif.fifo_din, 8'h9D);
    tick;
    tick;
    chk("we_idle", 8'(rif.busy), 8'd0);
    chk("we_err", 8'(rif.err), 8'd0);

    // FIFO0 never drains: soft_reset[0] in the 30th not-empty cycle, then drop len 2.
    rif.fifo_empty = 3'b110;
    rif.pkt_valid  = 1'b1;
    rif.data_in    = 8'h08;
    tick;
    rif.data_in = 8'h11;
    sr_cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      if (sr_cyc == 0) begin
        #1;
        if (rif.soft_reset[0]) sr_cyc = k;
        tick;
      end
    end
    chk("sr_cycle", 8'(sr_cyc), 8'd29);
    rif.fifo_empty = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sr_drop_busy", 8'(rif.busy), 8'd0);
      chk("sr_drop_we", 8'(rif.write_enb), 8'd0);
      tick;
    end
    send_pkt('{8'h05, 8'h77, 8'h72}, 3'b010);

    // Port 2 timeout: pulse on cycle 30 only.
    rif.fifo_empty = 3'b011;
    for (int i = 1; i <= 31; i++) begin
      #1;
      chk("to_a", 8'(rif.soft_reset), (i == 30) ? 8'b100 : 8'b000);
      tick;
    end
    rif.fifo_empty = 3'b111;
    tick;
    // A read on cycle 15 restarts the count: pulse on cycle 45.
    rif.fifo_empty = 3'b011;
    for (int i = 1; i <= 46; i++) begin
      rif.read_enb = (i == 15) ? 3'b100 : 3'b000;
      #1;
      chk("to_b", 8'(rif.soft_reset), (i == 45) ? 8'b100 : 8'b000);
      tick;
    end
    rif.read_enb   = 3'b000;
    rif.fifo_empty = 3'b111;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
